// File: rtl/friscv_pkg.sv
// friscv_pkg: shared constants and types for the front end of the core.
//   XLEN          - PC and instruction width
//   RESET_PC      - default PC loaded on reset
//   NOP_INSTR     - addi x0, x0, 0, shown on instr_out while nothing was fetched
//   fetch_state_t - fetch sequencer states
package friscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer.
//
// Ports:
//   clk_in, rstn_in         clock (rising edge), synchronous active-low reset
//   next_pc_in              output of the external next-PC mux
//   redirect_in             taken branch/jump, also the select of that mux
//   pc_plus4_out            pc_q + 4, fed to the mux a_in
//   imem_req_out/addr_out   fetch request and word-aligned address
//   imem_gnt_in             request accepted
//   imem_rvalid_in/rdata_in fetch response
//   instr_valid_out         instr_out/pc_out valid to decode
//   instr_ready_in          decode accepts (low = stall)
//   instr_out, pc_out       fetched instruction and its address
//
// Handshakes: imem_req_out/imem_addr_out are held stable until a cycle with
// imem_gnt_in=1; exactly one response (imem_rvalid_in) follows each grant and
// only one request is ever outstanding. instr_valid_out/instr_out/pc_out are
// held stable until a cycle with instr_ready_in=1 (or a redirect) consumes them.
module pc_fetch_unit
   import friscv_pkg::*;
#(
   parameter int unsigned       XLEN     = friscv_pkg::XLEN,
   parameter logic [XLEN-1:0]   RESET_PC = friscv_pkg::RESET_PC
) (
   input  logic            clk_in,
   input  logic            rstn_in,
   input  logic [XLEN-1:0] next_pc_in,
   input  logic            redirect_in,
   output logic [XLEN-1:0] pc_plus4_out,
   output logic            imem_req_out,
   output logic [XLEN-1:0] imem_addr_out,
   input  logic            imem_gnt_in,
   input  logic            imem_rvalid_in,
   input  logic [XLEN-1:0] imem_rdata_in,
   output logic            instr_valid_out,
   input  logic            instr_ready_in,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] req_addr_q;
   logic            kill_q;
   logic            req_q;
   logic            valid_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_out_q;

   logic [XLEN-1:0] next_pc_aligned;
   logic [XLEN-1:0] pc_eff;

   // Fetch addresses are always word aligned.
   assign next_pc_aligned = next_pc_in & ~XLEN'(3);

   // PC that is current after this edge; a new request launched on this edge
   // must use it so a same-cycle redirect is not missed.
   assign pc_eff = redirect_in ? next_pc_aligned : pc_q;

   assign pc_plus4_out    = pc_q + XLEN'(4);
   assign imem_req_out    = req_q;
   assign imem_addr_out   = req_addr_q;
   assign instr_valid_out = valid_q;
   assign instr_out       = instr_q;
   assign pc_out          = pc_out_q;

   always_ff @(posedge clk_in) begin
      if (!rstn_in) begin
         state      <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         kill_q     <= 1'b0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= XLEN'(NOP_INSTR);
         pc_out_q   <= RESET_PC;
      end else begin
         if (redirect_in) begin
            pc_q <= next_pc_aligned;
         end

         case (state)
            IDLE: begin
               state      <= REQ;
               req_q      <= 1'b1;
               req_addr_q <= pc_eff;
            end

            REQ: begin
               // The address stays put; a redirect only marks the eventual
               // response as stale, even if granted in the same cycle.
               if (redirect_in) begin
                  kill_q <= 1'b1;
               end
               if (imem_gnt_in) begin
                  state <= WAIT;
                  req_q <= 1'b0;
               end
            end

            WAIT: begin
               if (imem_rvalid_in) begin
                  if (kill_q || redirect_in) begin
                     kill_q     <= 1'b0;
                     state      <= REQ;
                     req_q      <= 1'b1;
                     req_addr_q <= pc_eff;
                  end else begin
                     instr_q  <= imem_rdata_in;
                     pc_out_q <= req_addr_q;
                     valid_q  <= 1'b1;
                     // No redirect here, so the mux is passing pc_q + 4.
                     pc_q     <= next_pc_aligned;
                     state    <= HOLD;
                  end
               end else if (redirect_in) begin
                  kill_q <= 1'b1;
               end
            end

            HOLD: begin
               if (redirect_in || instr_ready_in) begin
                  valid_q    <= 1'b0;
                  state      <= REQ;
                  req_q      <= 1'b1;
                  req_addr_q <= pc_eff;
               end
            end

            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: bench for pc_fetch_unit with a transaction-level model.
// The model keeps the architectural PC (redirect target, or last delivered
// PC + 4), the single outstanding memory transaction and whether a redirect
// has made it stale; delivered instructions go through an expected queue.
module tb_pc_fetch_unit;
   import friscv_pkg::*;

   localparam int W = 64;

   logic        clk_in = 1'b0;
   logic        rstn_in = 1'b0;
   logic [31:0] next_pc_in;
   logic        redirect_in = 1'b0;
   logic [31:0] pc_plus4_out;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        imem_gnt_in = 1'b0;
   logic        imem_rvalid_in = 1'b0;
   logic [31:0] imem_rdata_in = '0;
   logic        instr_valid_out;
   logic        instr_ready_in = 1'b0;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [31:0] redir_target = '0;

   // External next-PC mux (mux_2_way): a_in = pc_plus4_out, sel = redirect_in.
   assign next_pc_in = redirect_in ? redir_target : pc_plus4_out;

   pc_fetch_unit dut (
      .clk_in          (clk_in),
      .rstn_in         (rstn_in),
      .next_pc_in      (next_pc_in),
      .redirect_in     (redirect_in),
      .pc_plus4_out    (pc_plus4_out),
      .imem_req_out    (imem_req_out),
      .imem_addr_out   (imem_addr_out),
      .imem_gnt_in     (imem_gnt_in),
      .imem_rvalid_in  (imem_rvalid_in),
      .imem_rdata_in   (imem_rdata_in),
      .instr_valid_out (instr_valid_out),
      .instr_ready_in  (instr_ready_in),
      .instr_out       (instr_out),
      .pc_out          (pc_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [W-1:0] exp_q[$];

   logic [31:0] model_pc;
   logic        outstanding, out_killed, req_killed;
   logic [31:0] out_addr;
   logic        prev_req_hold, prev_valid_hold, gnt_given, deliver_due, req_due;
   logic [31:0] prev_addr, prev_instr, prev_pc;
   int          cyc, idle_cnt;
   logic        latency_mode;

   // stimulus policy (percentages)
   int          p_gnt, p_rv, p_rdy, p_redir, p_stray;
   logic        force_redir;
   logic [31:0] force_target;

   function automatic logic [31:0] mem_data(input logic [31:0] addr);
      if (addr == 32'h0) return 32'h00A0_0093;
      return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      model_pc        = 32'h0000_0000;
      outstanding     = 1'b0;
      out_killed      = 1'b0;
      req_killed      = 1'b0;
      out_addr        = '0;
      prev_req_hold   = 1'b0;
      prev_valid_hold = 1'b0;
      gnt_given       = 1'b0;
      deliver_due     = 1'b0;
      req_due         = 1'b0;
      prev_addr       = '0;
      prev_instr      = '0;
      prev_pc         = '0;
      cyc             = 0;
      idle_cnt        = 0;
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset(input logic stray);
      @(negedge clk_in);
      rstn_in        = 1'b0;
      imem_gnt_in    = 1'b0;
      imem_rvalid_in = stray;
      imem_rdata_in  = $urandom;
      redirect_in    = 1'b0;
      instr_ready_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      check_eq("rst_req", {31'b0, imem_req_out}, 32'd0);
      check_eq("rst_valid", {31'b0, instr_valid_out}, 32'd0);
      check_eq("rst_instr", instr_out, NOP_INSTR);
      check_eq("rst_pc_out", pc_out, 32'h0000_0000);
      check_eq("rst_plus4", pc_plus4_out, 32'd4);
      model_reset();
      // Next edge is the first with reset released; a stray rvalid in IDLE
      // must have no effect.
      rstn_in        = 1'b1;
      imem_rvalid_in = stray;
   endtask

   task automatic cycle();
      logic        o_req, o_valid, gnt, rv, rdy, rdr;
      logic [31:0] o_addr, o_instr, o_pc, tgt;
      logic [W-1:0] e;
      @(negedge clk_in);
      cyc++;
      o_req   = imem_req_out;
      o_addr  = imem_addr_out;
      o_valid = instr_valid_out;
      o_instr = instr_out;
      o_pc    = pc_out;

      check_eq("pc_plus4", pc_plus4_out, model_pc + 32'd4);

      if (latency_mode && cyc == 1) begin
         check_eq("lat_req", {31'b0, o_req}, 32'd1);
         check_eq("lat_addr", o_addr, 32'h0000_0000);
      end
      if (latency_mode && cyc == 3)
         check_eq("lat_valid", {31'b0, o_valid}, 32'd1);

      if (req_due) begin
         check_eq("reissue_req", {31'b0, o_req}, 32'd1);
         check_eq("reissue_valid", {31'b0, o_valid}, 32'd0);
      end

      if (deliver_due) begin
         check_eq("deliver_valid", {31'b0, o_valid}, 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("deliver_instr", o_instr, e[31:0]);
            check_eq("deliver_pc", o_pc, e[63:32]);
         end
      end else if (prev_valid_hold) begin
         check_eq("hold_valid", {31'b0, o_valid}, 32'd1);
         check_eq("hold_instr", o_instr, prev_instr);
         check_eq("hold_pc", o_pc, prev_pc);
      end else if (!req_due) begin
         check_eq("no_spurious_valid", {31'b0, o_valid}, 32'd0);
      end

      if (o_valid) check_eq("no_req_in_hold", {31'b0, o_req}, 32'd0);

      if (prev_req_hold) begin
         check_eq("req_stable", {31'b0, o_req}, 32'd1);
         check_eq("addr_stable", o_addr, prev_addr);
      end else if (gnt_given) begin
         check_eq("req_drop_after_gnt", {31'b0, o_req}, 32'd0);
      end else if (o_req) begin
         check_eq("req_addr", o_addr, model_pc);
         req_killed = 1'b0;
      end

      if (!o_req && !o_valid && !outstanding) idle_cnt++;
      else idle_cnt = 0;
      check_eq("watchdog", {31'b0, idle_cnt > 3}, 32'd0);
      if (idle_cnt > 3) idle_cnt = 0;

      // choose inputs for the coming edge
      gnt = o_req && ($urandom_range(0, 99) < p_gnt);
      rv  = outstanding ? ($urandom_range(0, 99) < p_rv) : ($urandom_range(0, 99) < p_stray);
      rdy = $urandom_range(0, 99) < p_rdy;
      rdr = force_redir || ($urandom_range(0, 99) < p_redir);
      if (force_redir) tgt = force_target;
      else if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF8 | ($urandom & 32'h7);
      else tgt = $urandom & 32'h0000_0FFF;
      force_redir = 1'b0;

      imem_gnt_in    = gnt;
      imem_rvalid_in = rv;
      imem_rdata_in  = (rv && outstanding) ? mem_data(out_addr) : $urandom;
      instr_ready_in = rdy;
      redirect_in    = rdr;
      redir_target   = tgt;

      // model the effect of that edge
      prev_req_hold   = o_req && !gnt;
      prev_addr       = o_addr;
      gnt_given       = o_req && gnt;
      prev_valid_hold = o_valid && !rdy && !rdr;
      prev_instr      = o_instr;
      prev_pc         = o_pc;
      req_due         = o_valid && (rdy || rdr);
      deliver_due     = 1'b0;
      if (o_req && rdr) req_killed = 1'b1;
      if (outstanding && rv) begin
         if (out_killed || rdr) begin
            req_due = 1'b1;
         end else begin
            exp_q.push_back({out_addr, mem_data(out_addr)});
            deliver_due = 1'b1;
            model_pc    = out_addr + 32'd4;
         end
         outstanding = 1'b0;
      end else if (outstanding && rdr) begin
         out_killed = 1'b1;
      end
      if (gnt_given) begin
         outstanding = 1'b1;
         out_addr    = o_addr;
         out_killed  = req_killed || rdr;
         req_killed  = 1'b0;
      end
      if (rdr) model_pc = tgt & ~32'h3;
   endtask

   task automatic run_until_wait();
      for (int i = 0; i < 20 && !outstanding; i++) cycle();
      check_eq("reach_wait", {31'b0, outstanding}, 32'd1);
   endtask

   task automatic set_policy(input int g, input int r, input int y, input int d, input int s);
      p_gnt = g; p_rv = r; p_rdy = y; p_redir = d; p_stray = s;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      force_redir  = 1'b0;
      force_target = '0;
      latency_mode = 1'b1;
      model_reset();
      set_policy(100, 100, 100, 0, 0);

      // zero-wait memory: first fetch at address 0, then 4, 8
      do_reset(1'b0);
      repeat (9) cycle();
      latency_mode = 1'b0;

      // grant held off for several cycles
      p_gnt = 0;
      repeat (4) cycle();
      p_gnt = 100;
      repeat (8) cycle();

      // redirect while waiting for the response
      p_rv = 0;
      run_until_wait();
      force_redir  = 1'b1;
      force_target = 32'h0000_0102;
      cycle();
      p_rv = 100;
      repeat (8) cycle();

      // decode stall
      p_rdy = 0;
      for (int i = 0; i < 15 && !instr_valid_out; i++) cycle();
      repeat (5) cycle();
      p_rdy = 100;
      repeat (4) cycle();

      // PC wrap from the top of the address space
      force_redir  = 1'b1;
      force_target = 32'hFFFF_FFFC;
      cycle();
      repeat (10) cycle();

      // reset while waiting, followed by a stray response
      p_rv = 0;
      run_until_wait();
      do_reset(1'b1);
      p_rv = 100;
      repeat (8) cycle();

      // randomized traffic with occasional resets
      set_policy(60, 50, 60, 8, 5);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset(1'($urandom_range(0, 1)));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
